// File: rtl/axi_wdata_drain_if.sv
// AXI4 W-channel bundle between the write-data drain and its slave.
// The master drives the beat; the slave answers with m_wready.
interface axi_wdata_drain_if #(
  parameter int DATA_W = 128
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wlast;

  modport master (
    output m_wvalid,
    output m_wdata,
    output m_wstrb,
    output m_wlast,
    input  m_wready
  );

  modport slave (
    input  m_wvalid,
    input  m_wdata,
    input  m_wstrb,
    input  m_wlast,
    output m_wready
  );
endinterface

// File: rtl/axi_wdata_drain.sv
// Pops AWLEN+1 FIFO words and replays them as AXI4 W beats.
// Optional AXI_WDRAIN_STATS_EN adds beat/burst counters.
module axi_wdata_drain #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              fifo_rd_en_o,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  axi_wdata_drain_if.master w,
`ifdef AXI_WDRAIN_STATS_EN
  output logic [31:0]       stat_beats_o,
  output logic [31:0]       stat_bursts_o,
`endif
  output logic              busy_o
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [LEN_W:0]    fetch_q, fetch_d;
  logic [LEN_W:0]    sent_q, sent_d;
  logic              infl_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic              valid;
  logic              pop;
  logic              push;
  logic              last;
  logic              rd_en;
  logic [2:0]        fill;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && w.m_wready;
  assign push  = infl_q;
  assign last  = (sent_q == ONE);

  // Slots claimed after this edge; the head beat leaving frees one.
  assign fill = {1'b0, occ_q} + {2'b0, infl_q}
              - {2'b0, pop};

  assign rd_en = (state_q == ACTIVE) &&
                 !fifo_empty_i &&
                 (fetch_q != '0) &&
                 (fill < 3'd2);

  assign fifo_rd_en_o = rd_en;
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q == ACTIVE);
  assign w.m_wvalid   = valid;
  assign w.m_wdata    = buf0_q;
  assign w.m_wstrb    = {STRB_W{1'b1}};
  assign w.m_wlast    = valid && last;

  // Burst FSM with fetch and send down-counters.
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = ACTIVE;
          fetch_d = {1'b0, cmd_len_i} + ONE;
          sent_d  = {1'b0, cmd_len_i} + ONE;
        end
      end
      ACTIVE: begin
        if (rd_en) fetch_d = fetch_q - ONE;
        if (pop) begin
          sent_d = sent_q - ONE;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-slot buffer; slot 0 is always the presented beat.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rd_data_i;
        else               buf1_d = fifo_rd_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rd_data_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data_i;
        end
      end
      default: ;
    endcase
  end

  // State, counters and buffer; reset drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_q <= '0;
      sent_q  <= '0;
      infl_q  <= 1'b0;
      occ_q   <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      sent_q  <= sent_d;
      infl_q  <= rd_en;
      occ_q   <= occ_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // A third buffered word would mean the fetch rule is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && occ_q == 2'd2));
    end
  end

`ifdef AXI_WDRAIN_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] bursts_q, bursts_d;

  always_comb begin
    beats_d  = beats_q;
    bursts_d = bursts_q;
    if (pop) beats_d = beats_q + 32'd1;
    if (pop && last) bursts_d = bursts_q + 32'd1;
  end

  // Free-running wrap-around beat and burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q  <= '0;
      bursts_q <= '0;
    end else begin
      beats_q  <= beats_d;
      bursts_q <= bursts_d;
    end
  end

  assign stat_beats_o  = beats_q;
  assign stat_bursts_o = bursts_q;
`endif

endmodule

// File: tb/tb_axi_wdata_drain.sv
// Directed bench for axi_wdata_drain with a FIFO model.
// Checks beat order, WLAST, handshake hold, fetch limits and reset.
module tb_axi_wdata_drain;
  localparam int DW = 128;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          rd_en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          busy;
`ifdef AXI_WDRAIN_STATS_EN
  logic [31:0]   st_beats;
  logic [31:0]   st_bursts;
`endif

  axi_wdata_drain_if #(.DATA_W(DW)) w ();

  axi_wdata_drain #(
    .DATA_W(DW),
    .LEN_W (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_len_i     (cmd_len),
    .fifo_rd_en_o  (rd_en),
    .fifo_empty_i  (fifo_empty),
    .fifo_rd_data_i(rd_data),
    .w             (w.master),
`ifdef AXI_WDRAIN_STATS_EN
    .stat_beats_o  (st_beats),
    .stat_bursts_o (st_bursts),
`endif
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] expq[$];
  int            rdn = 0;
  int            rd0, beats, exp_n;
  int            stepn, first_s, last_s;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            mode = 0;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic          pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [DW-1:0] exp_d;

  // FIFO model: one-cycle read latency, flushed by rst.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      rd_data <= '0;
    end else if (rd_en) begin
      rdn <= rdn + 1;
      if (fq.size() > 0) rd_data <= fq.pop_front();
      else rd_data <= {32{4'hd}};
    end
  end

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fq.push_back({4{32'(base + i)}});
      expq.push_back({4{32'(base + i)}});
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc++;
    stepn++;
    if (mode == 0) w.m_wready = 1'b1;
    else w.m_wready = (cyc % 4 == 0) || (cyc % 4 == 3);
    fifo_empty = (fq.size() == 0);
    #1;
    check("rd_while_empty", 128'(rd_en & fifo_empty), '0);
    if (pv && !pr) begin
      check("hold_valid", 128'(w.m_wvalid), 128'(1));
      check("hold_data", w.m_wdata, pd);
      check("hold_last", 128'(w.m_wlast), 128'(pl));
    end
    if (w.m_wvalid && w.m_wready) begin
      beats++;
      if (first_s < 0) first_s = stepn;
      last_s = stepn;
      exp_d = (expq.size() > 0) ? expq.pop_front() : '0;
      check("wdata", w.m_wdata, exp_d);
      check("wlast", 128'(w.m_wlast), 128'(beats == exp_n));
      check("wstrb", 128'(w.m_wstrb), 128'(16'hffff));
    end
    check("outstanding",
          128'((rdn - rd0 + int'(rd_en) - beats) <= 2),
          128'(1));
    pv = w.m_wvalid;
    pr = w.m_wready;
    pd = w.m_wdata;
    pl = w.m_wlast;
  endtask

  task automatic start(input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = 8'(len);
    w.m_wready = 1'b0;
    fifo_empty = (fq.size() == 0);
    #1;
    check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    beats = 0;
    exp_n = len + 1;
    rd0 = rdn;
    stepn = 0;
    first_s = -1;
    last_s = -1;
    pv = 1'b0;
  endtask

  task automatic run(input int n, input int budget);
    for (int i = 0; i < budget && beats < n; i++) step();
    check("beats_done", 128'(beats), 128'(n));
  endtask

  task automatic finish_burst(input string tag, input int pops);
    step();
    check({tag, "_ready"}, 128'(cmd_ready), 128'(1));
    check({tag, "_busy"}, 128'(busy), '0);
    check({tag, "_pops"}, 128'(rdn - rd0), 128'(pops));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    w.m_wready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_rd_en", 128'(rd_en), '0);
    check("rst_wvalid", 128'(w.m_wvalid), '0);
    check("rst_wlast", 128'(w.m_wlast), '0);
    check("rst_wdata", w.m_wdata, '0);
    check("rst_busy", 128'(busy), '0);
    @(negedge clk);
    rst = 1'b0;
    pv = 1'b0;
    expq.delete();
  endtask

  initial begin
    w.m_wready = 1'b0;
    do_reset();

    fq.push_back({16{8'ha5}});
    expq.push_back({16{8'ha5}});
    fq.push_back({16{8'h5a}});
    mode = 0;
    start(0);
    run(1, 20);
    finish_burst("single", 1);
    check("single_left", 128'(fq.size()), 128'(1));
    fq.delete();

    load(16, 32'h1000);
    fq.push_back({4{32'hdead0017}});
    start(15);
    run(16, 60);
    check("full_first", 128'(first_s), 128'(3));
    check("full_span", 128'(last_s - first_s), 128'(15));
    finish_burst("full", 16);
    check("full_left", 128'(fq.size()), 128'(1));
    fq.delete();

    load(8, 32'h2000);
    fq.push_back({4{32'hdead0009}});
    mode = 1;
    start(7);
    run(8, 100);
    finish_burst("bp", 8);
    fq.delete();

    mode = 0;
    fq.push_back({4{32'h3000}});
    fq.push_back({4{32'h3001}});
    for (int i = 0; i < 4; i++) expq.push_back({4{32'(32'h3000 + i)}});
    start(3);
    run(2, 20);
    for (int i = 0; i < 10; i++) begin
      step();
      check("gap_wvalid", 128'(w.m_wvalid), '0);
    end
    fq.push_back({4{32'h3002}});
    fq.push_back({4{32'h3003}});
    run(4, 30);
    finish_burst("under", 4);

    load(10, 32'h4000);
    start(255);
    run(5, 30);
    do_reset();
    check("mid_rst_fifo", 128'(fq.size()), '0);
    load(2, 32'h5000);
    start(1);
    run(2, 20);
    finish_burst("post_rst", 2);

`ifdef AXI_WDRAIN_STATS_EN
    do_reset();
    check("stat_beats_rst", 128'(st_beats), '0);
    check("stat_bursts_rst", 128'(st_bursts), '0);
    load(1, 32'h6000);
    start(0);
    run(1, 20);
    step();
    load(4, 32'h6100);
    start(3);
    run(4, 30);
    step();
    load(16, 32'h6200);
    start(15);
    run(16, 60);
    step();
    check("stat_beats", 128'(st_beats), 128'(21));
    check("stat_bursts", 128'(st_bursts), 128'(3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
